// File: rtl/spc_cfg_pkg.sv
// rtl/spc_cfg_pkg.sv - shared layout constants and FSM states for the vin_spc config serializer

package spc_cfg_pkg;

  localparam int SPC_CFG_NBITS = 33;

  // Field offsets (LSB position) and widths inside the vin_spc configuration word; EnLF is the MSB.
  localparam int SPC_RE_LSB       = 0;   localparam int SPC_RE_W       = 1;
  localparam int SPC_FS_LSB       = 1;   localparam int SPC_FS_W       = 1;
  localparam int SPC_GD_LSB       = 2;   localparam int SPC_GD_W       = 1;
  localparam int SPC_NS_LSB       = 3;   localparam int SPC_NS_W       = 1;
  localparam int SPC_CE_LSB       = 4;   localparam int SPC_CE_W       = 1;
  localparam int SPC_GS_LSB       = 5;   localparam int SPC_GS_W       = 4;
  localparam int SPC_IQ_LSB       = 9;   localparam int SPC_IQ_W       = 1;
  localparam int SPC_F_LSB        = 10;  localparam int SPC_F_W        = 4;
  localparam int SPC_CAPSEL_LSB   = 14;  localparam int SPC_CAPSEL_W   = 4;
  localparam int SPC_CCOMPSEL_LSB = 18;  localparam int SPC_CCOMPSEL_W = 4;
  localparam int SPC_ENRDEGHF_LSB = 22;  localparam int SPC_ENRDEGHF_W = 1;
  localparam int SPC_ENRDEG_LSB   = 23;  localparam int SPC_ENRDEG_W   = 1;
  localparam int SPC_DP_LSB       = 24;  localparam int SPC_DP_W       = 3;
  localparam int SPC_DN_LSB       = 27;  localparam int SPC_DN_W       = 3;
  localparam int SPC_ENHF_LSB     = 30;  localparam int SPC_ENHF_W     = 1;
  localparam int SPC_ENMF_LSB     = 31;  localparam int SPC_ENMF_W     = 1;
  localparam int SPC_ENLF_LSB     = 32;  localparam int SPC_ENLF_W     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } spc_cfg_state_e;

endpackage

// File: rtl/spc_cfg_phase_tick.sv
// rtl/spc_cfg_phase_tick.sv - DIV-cycle phase counter with terminal-count pulse

module spc_cfg_phase_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // Wrapping on tick restarts the count at every state boundary without an explicit clear.
  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/spc_cfg_serializer.sv
// rtl/spc_cfg_serializer.sv - shifts a parallel config word into vin_spc with its own shift clock and latch

module spc_cfg_serializer
  import spc_cfg_pkg::*;
#(
  parameter int NBITS     = SPC_CFG_NBITS,
  parameter int DIV       = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [NBITS-1:0] Cfg_word,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic             Cfg_out,
  output logic             Cfg_clk,
  output logic             Cfg_latch
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  spc_cfg_state_e   state, state_nxt;
  logic [NBITS-1:0] shadow, shadow_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             done_nxt;
  logic             phase_clr;
  logic             tick;

  assign phase_clr = (state == IDLE);

  spc_cfg_phase_tick #(
    .DIV (DIV)
  ) u_phase (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (phase_clr),
    .tick (tick)
  );

  // The outgoing bit always sits at the shadow edge, so Cfg_out is a flop with no input path.
  assign Cfg_out = LSB_FIRST ? shadow[0] : shadow[NBITS-1];

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          shadow_nxt  = Cfg_word;
          bit_cnt_nxt = '0;
          state_nxt   = LOW;
        end
      end
      LOW: begin
        if (tick) state_nxt = HIGH;
      end
      HIGH: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = LATCH;
          end else begin
            bit_cnt_nxt = bit_cnt + CW'(1);
            shadow_nxt  = LSB_FIRST ? (shadow >> 1) : (shadow << 1);
            state_nxt   = LOW;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          shadow_nxt = '0;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Cfg_clk   <= 1'b0;
      Cfg_latch <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      bit_cnt   <= bit_cnt_nxt;
      Busy      <= (state_nxt != IDLE);
      Done      <= done_nxt;
      Cfg_clk   <= (state_nxt == HIGH);
      Cfg_latch <= (state_nxt == LATCH);
    end
  end

endmodule

// File: tb/tb_spc_cfg_serializer.sv
// tb/tb_spc_cfg_serializer.sv - randomized self-checking bench for spc_cfg_serializer

module tb_spc_cfg_serializer;
  import spc_cfg_pkg::*;

  localparam int NB  [4] = '{33, 8, 4, 1};
  localparam int DV  [4] = '{2, 1, 1, 3};
  localparam bit LSB [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk;
  logic        rst;
  logic [32:0] w   [4];
  logic        st  [4];
  logic        bsy [4];
  logic        dn  [4];
  logic        co  [4];
  logic        cc  [4];
  logic        cl  [4];

  int total = 0;
  int bad   = 0;

  spc_cfg_serializer #(.NBITS(33), .DIV(2), .LSB_FIRST(1'b0)) u_dut0 (
    .Clk(clk), .Reset(rst), .Cfg_word(w[0][32:0]), .Start(st[0]), .Busy(bsy[0]),
    .Done(dn[0]), .Cfg_out(co[0]), .Cfg_clk(cc[0]), .Cfg_latch(cl[0]));
  spc_cfg_serializer #(.NBITS(8), .DIV(1), .LSB_FIRST(1'b1)) u_dut1 (
    .Clk(clk), .Reset(rst), .Cfg_word(w[1][7:0]), .Start(st[1]), .Busy(bsy[1]),
    .Done(dn[1]), .Cfg_out(co[1]), .Cfg_clk(cc[1]), .Cfg_latch(cl[1]));
  spc_cfg_serializer #(.NBITS(4), .DIV(1), .LSB_FIRST(1'b0)) u_dut2 (
    .Clk(clk), .Reset(rst), .Cfg_word(w[2][3:0]), .Start(st[2]), .Busy(bsy[2]),
    .Done(dn[2]), .Cfg_out(co[2]), .Cfg_clk(cc[2]), .Cfg_latch(cl[2]));
  spc_cfg_serializer #(.NBITS(1), .DIV(3), .LSB_FIRST(1'b0)) u_dut3 (
    .Clk(clk), .Reset(rst), .Cfg_word(w[3][0:0]), .Start(st[3]), .Busy(bsy[3]),
    .Done(dn[3]), .Cfg_out(co[3]), .Cfg_clk(cc[3]), .Cfg_latch(cl[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream vin_spc register: shifts on Cfg_clk rise, copies to outputs on Cfg_latch rise.
  logic [32:0] ds_sr = '0;
  logic [32:0] ds_q  = '0;
  always @(posedge cc[0]) ds_sr <= {ds_sr[31:0], co[0]};
  always @(posedge cl[0]) ds_q  <= ds_sr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [32:0] rnd33();
    return 33'({$urandom(), $urandom()});
  endfunction

  // Watches one transfer from its first busy cycle through Done and compares against the word rules.
  task automatic observe(input int d, input logic [32:0] wd, input logic st_after, input logic [32:0] w_after);
    int n, dv, busy_n, rises, lat_n, last_chg, rise_idx, stab_bad, budget;
    logic [32:0] got, mask;
    logic prev_cc, prev_co, fin;
    n = NB[d]; dv = DV[d];
    mask = (33'd1 << n) - 33'd1;
    budget = 2 * dv * n + dv + 8;
    got = '0; busy_n = 0; rises = 0; lat_n = 0; last_chg = 0; rise_idx = 0; stab_bad = 0;
    prev_cc = 1'b0; fin = 1'b0;
    @(negedge clk);
    chk($sformatf("d%0d_busy_first", d), 64'(bsy[d]), 64'd1);
    chk($sformatf("d%0d_done_pulse_width", d), 64'(dn[d]), 64'd0);
    st[d] = st_after;
    w[d]  = w_after;
    prev_co = co[d];
    for (int smp = 0; smp < budget && !fin; smp++) begin
      if (smp > 0) @(negedge clk);
      if (dn[d]) begin
        fin = 1'b1;
        chk($sformatf("d%0d_done_outs", d), 64'({bsy[d], co[d], cc[d], cl[d]}), 64'd0);
      end else begin
        if (bsy[d]) busy_n++;
        if (cl[d]) lat_n++;
        if (cc[d] && !prev_cc) begin
          if (smp - last_chg < dv) stab_bad++;
          if (rises < n) got[LSB[d] ? rises : n - 1 - rises] = co[d];
          rise_idx = smp;
          rises++;
        end
        if (!cc[d] && prev_cc && last_chg > rise_idx) stab_bad++;
        if (co[d] !== prev_co) last_chg = smp;
        prev_cc = cc[d];
        prev_co = co[d];
      end
    end
    chk($sformatf("d%0d_done_seen", d), 64'(fin), 64'd1);
    chk($sformatf("d%0d_busy_cycles", d), 64'(busy_n), 64'(2 * dv * n + dv));
    chk($sformatf("d%0d_clk_rises", d), 64'(rises), 64'(n));
    chk($sformatf("d%0d_latch_cycles", d), 64'(lat_n), 64'(dv));
    chk($sformatf("d%0d_serial_word", d), 64'(got), 64'(wd & mask));
    chk($sformatf("d%0d_data_stable", d), 64'(stab_bad), 64'd0);
  endtask

  task automatic xfer(input int d, input logic [32:0] wd);
    w[d]  = wd;
    st[d] = 1'b1;
    observe(d, wd, 1'b0, rnd33());
  endtask

  initial begin
    logic [32:0] wd;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      w[i]  = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("d%0d_reset_state", i), 64'({bsy[i], dn[i], co[i], cc[i], cl[i]}), 64'd0);

    // Reset mid-transfer with an all-ones word so Cfg_out is high when reset hits.
    w[0] = {33{1'b1}};
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (38) @(negedge clk);
    chk("mid_busy", 64'({bsy[0], co[0]}), 64'd3);
    #3 rst = 1'b1;
    #1 chk("async_reset_outs", 64'({bsy[0], dn[0], co[0], cc[0], cl[0]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_resume", 64'({bsy[0], cc[0], cl[0]}), 64'd0);

    xfer(0, 33'h1_2345_6789);
    xfer(1, 33'h0A5);

    // Downstream integration through the package field layout.
    wd = rnd33();
    wd[SPC_GS_LSB +: SPC_GS_W] = 4'hC;
    wd[SPC_F_LSB +: SPC_F_W]   = 4'h3;
    wd[SPC_ENLF_LSB]           = 1'b1;
    xfer(0, wd);
    @(negedge clk);
    chk("ds_gs", 64'(ds_q[SPC_GS_LSB +: SPC_GS_W]), 64'hC);
    chk("ds_f", 64'(ds_q[SPC_F_LSB +: SPC_F_W]), 64'h3);
    chk("ds_enlf", 64'(ds_q[SPC_ENLF_LSB]), 64'd1);
    chk("ds_word", 64'(ds_q), 64'(wd));

    // Start held high: second word is captured in the Done cycle with no gap.
    w[2] = 33'h9;
    st[2] = 1'b1;
    observe(2, 33'h9, 1'b1, 33'h6);
    observe(2, 33'h6, 1'b0, rnd33());

    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 4; d++)
        xfer(d, rnd33());

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("d%0d_idle_end", i), 64'({bsy[i], dn[i], cc[i], cl[i]}), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
